// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the boot-time instruction loader.
package loader_pkg;

  // Loader FSM states, in the order a frame is parsed.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SYNC   = 3'd1,
    LEN_LO = 3'd2,
    LEN_HI = 3'd3,
    DATA   = 3'd4,
    CHECK  = 3'd5,
    DONE   = 3'd6,
    ERROR  = 3'd7
  } state_e;

  // Frame marker that must precede the length field.
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  // Values reported on err_o.
  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_LEN  = 2'd1;
  localparam logic [1:0] ERR_SUM  = 2'd2;

endpackage

// File: rtl/instr_loader_if.sv
// Byte-stream input and instruction-memory write bus of the loader.
// master: the environment (serial receiver and memory); slave: the loader.
interface instr_loader_if #(
  parameter int AddressWidth = 10
) ();

  logic                    rx_valid_i;
  logic [7:0]              rx_data_i;
  logic                    rx_ready_o;
  logic                    imem_wr_en_o;
  logic [AddressWidth-1:0] imem_wr_addr_o;
  logic [31:0]             imem_wr_data_o;

  modport master (
    output rx_valid_i,
    output rx_data_i,
    input  rx_ready_o,
    input  imem_wr_en_o,
    input  imem_wr_addr_o,
    input  imem_wr_data_o
  );

  modport slave (
    input  rx_valid_i,
    input  rx_data_i,
    output rx_ready_o,
    output imem_wr_en_o,
    output imem_wr_addr_o,
    output imem_wr_data_o
  );

endinterface

// File: rtl/instr_loader_byte_packer.sv
// Collects payload bytes little-endian into 32-bit words and emits a
// registered one-cycle word_valid_o pulse the cycle after the fourth byte.
module byte_packer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic [1:0]  lane_o,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  logic [1:0]  lane_q, lane_d;
  logic [23:0] buf_q, buf_d;
  logic [31:0] word_q, word_d;
  logic        word_valid_q, word_valid_d;

  // Place each byte into its lane; the fourth byte completes the word.
  always_comb begin
    lane_d       = lane_q;
    buf_d        = buf_q;
    word_d       = word_q;
    word_valid_d = 1'b0;
    if (clear_i) begin
      lane_d = 2'd0;
      buf_d  = 24'd0;
    end else if (byte_valid_i) begin
      case (lane_q)
        2'd0:    buf_d[7:0]   = byte_i;
        2'd1:    buf_d[15:8]  = byte_i;
        2'd2:    buf_d[23:16] = byte_i;
        default: begin
          word_d       = {byte_i, buf_q};
          word_valid_d = 1'b1;
        end
      endcase
      lane_d = lane_q + 2'd1;
    end
  end

  // Lane, partial word and output word registers; reset drops any partial word.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lane_q       <= 2'd0;
      buf_q        <= 24'd0;
      word_q       <= 32'd0;
      word_valid_q <= 1'b0;
    end else begin
      lane_q       <= lane_d;
      buf_q        <= buf_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
    end
  end

  assign lane_o       = lane_q;
  assign word_valid_o = word_valid_q;
  assign word_o       = word_q;

endmodule

// File: rtl/instr_loader.sv
// Boot loader: parses sync / length / payload / checksum frames from a byte
// stream, writes words into instruction memory and releases the core only
// after a load with a matching checksum.
module instr_loader
  import loader_pkg::*;
#(
  parameter int AddressWidth = 10
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  instr_loader_if.slave        bus,
  output logic                 cpu_rst_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [1:0]           err_o
);

  localparam int          CntWidth = AddressWidth - 1;
  localparam logic [16:0] Capacity = 17'(1) << (AddressWidth - 2);

  state_e                  state_q, state_d;
  logic [7:0]              len_lo_q, len_lo_d;
  logic [15:0]             len_q, len_d;
  logic [CntWidth-1:0]     word_cnt_q, word_cnt_d;
  logic [7:0]              checksum_q, checksum_d;
  logic [1:0]              err_q, err_d;
  logic [AddressWidth-1:0] wr_addr_q, wr_addr_d;

  logic        rx_ready;
  logic        accept;
  logic [15:0] len_n;
  logic        pack_clear;
  logic        pack_valid;
  logic [1:0]  pack_lane;
  logic        pack_word_valid;
  logic [31:0] pack_word;

  assign rx_ready = (state_q == SYNC) || (state_q == LEN_LO) || (state_q == LEN_HI) ||
                    (state_q == DATA) || (state_q == CHECK);
  assign accept   = bus.rx_valid_i && rx_ready;

  byte_packer u_packer (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clear_i      (pack_clear),
    .byte_valid_i (pack_valid),
    .byte_i       (bus.rx_data_i),
    .lane_o       (pack_lane),
    .word_valid_o (pack_word_valid),
    .word_o       (pack_word)
  );

  // Next-state logic: frame parsing, length validation, word counting, checksum.
  always_comb begin
    state_d    = state_q;
    len_lo_d   = len_lo_q;
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    checksum_d = checksum_q;
    err_d      = err_q;
    wr_addr_d  = wr_addr_q;
    len_n      = {bus.rx_data_i, len_lo_q};
    pack_clear = 1'b0;
    pack_valid = 1'b0;
    case (state_q)
      IDLE, DONE, ERROR: begin
        if (start_i) begin
          state_d    = SYNC;
          err_d      = ERR_NONE;
          checksum_d = 8'd0;
          word_cnt_d = '0;
        end
      end
      SYNC: begin
        if (accept && (bus.rx_data_i == SYNC_BYTE)) state_d = LEN_LO;
      end
      LEN_LO: begin
        if (accept) begin
          len_lo_d = bus.rx_data_i;
          state_d  = LEN_HI;
        end
      end
      LEN_HI: begin
        if (accept) begin
          len_d = len_n;
          if ((len_n == 16'd0) || ({1'b0, len_n} > Capacity)) begin
            state_d = ERROR;
            err_d   = ERR_LEN;
          end else begin
            state_d    = DATA;
            word_cnt_d = '0;
            checksum_d = 8'd0;
            pack_clear = 1'b1;
          end
        end
      end
      DATA: begin
        if (accept) begin
          pack_valid = 1'b1;
          checksum_d = checksum_q ^ bus.rx_data_i;
          if (pack_lane == 2'd3) begin
            wr_addr_d  = AddressWidth'({word_cnt_q, 2'b00});
            word_cnt_d = word_cnt_q + 1'b1;
            if ((int'(word_cnt_q) + 1) == int'(len_q)) state_d = CHECK;
          end
        end
      end
      CHECK: begin
        if (accept) begin
          if (bus.rx_data_i == checksum_q) begin
            state_d = DONE;
          end else begin
            state_d = ERROR;
            err_d   = ERR_SUM;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      len_lo_q   <= 8'd0;
      len_q      <= 16'd0;
      word_cnt_q <= '0;
      checksum_q <= 8'd0;
      err_q      <= ERR_NONE;
      wr_addr_q  <= '0;
    end else begin
      state_q    <= state_d;
      len_lo_q   <= len_lo_d;
      len_q      <= len_d;
      word_cnt_q <= word_cnt_d;
      checksum_q <= checksum_d;
      err_q      <= err_d;
      wr_addr_q  <= wr_addr_d;
    end
  end

  assign bus.rx_ready_o     = rx_ready;
  assign bus.imem_wr_en_o   = pack_word_valid;
  assign bus.imem_wr_addr_o = wr_addr_q;
  assign bus.imem_wr_data_o = pack_word;
  assign busy_o             = rx_ready;
  assign done_o             = (state_q == DONE);
  assign cpu_rst_o          = (state_q != DONE);
  assign err_o              = err_q;

endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
Boot-time loader that sits directly upstream of the processor's instruction memory write port and core reset. It consumes a byte stream from a serial receiver using a valid/ready handshake. It parses a framed image (sync byte, 16-bit word count, little-endian payload, XOR checksum) and writes each assembled 32-bit word into instruction memory. The core is held in reset until a load completes with a good checksum.

Parameters:
AddressWidth, 10, byte-address width of instruction memory; capacity = 2^(AddressWidth-2) words (256 at default)

Ports:
clk_i  input  1  clock, all logic on rising edge
rst_i  input  1  synchronous active-high reset
start_i  input  1  single-cycle request to begin a load
rx_valid_i  input  1  rx_data_i holds a valid byte
rx_data_i  input  8  received byte
rx_ready_o  output  1  loader accepts a byte this cycle
imem_wr_en_o  output  1  instruction memory write strobe, one cycle per word
imem_wr_addr_o  output  AddressWidth  byte address of write, always word aligned
imem_wr_data_o  output  32  word to write
cpu_rst_o  output  1  holds the core in reset, active-high
busy_o  output  1  load in progress
done_o  output  1  last load succeeded
err_o  output  2  0 none, 1 bad length, 2 checksum mismatch

Behaviour:
- Clock and reset: one clock, clk_i. rst_i is synchronous and active-high; the polarity and synchronicity are fixed.
- Reset values: state IDLE, rx_ready_o 0, imem_wr_en_o 0, imem_wr_addr_o 0, imem_wr_data_o 0, cpu_rst_o 1, busy_o 0, done_o 0, err_o 0, checksum 0, counters 0.
- Byte acceptance: a byte is accepted on a cycle where rx_valid_i and rx_ready_o are both 1. rx_ready_o is 1 in SYNC, LEN_LO, LEN_HI, DATA and CHECK, and 0 elsewhere. rx_valid_i gaps of any length are tolerated.
- busy_o = 1 in SYNC through CHECK. cpu_rst_o = 0 only in DONE.
- IDLE: start_i -> SYNC.
- SYNC: accepted byte 0xA5 -> LEN_LO. Any other byte is discarded and the state stays SYNC.
- LEN_LO: accepted byte becomes N[7:0] -> LEN_HI.
- LEN_HI: accepted byte becomes N[15:8].
  - If N == 0 or N > 2^(AddressWidth-2): -> ERROR with err_o = 1. No writes occur.
  - Otherwise -> DATA with word_cnt = 0, lane = 0, checksum = 0.
- DATA, byte handling: each accepted byte goes into lane `lane` of the word buffer. The first byte goes to bits [7:0], the fourth to [31:24]. The checksum is XORed with the byte, and lane increments modulo 4.
- DATA, word write:
  - On acceptance of lane 3: the next cycle shows imem_wr_en_o = 1, imem_wr_addr_o = word_cnt*4 (truncated to AddressWidth) and imem_wr_data_o = the assembled word. Latency is one cycle and the strobe is one cycle wide.
  - word_cnt then increments; it is AddressWidth-1 bits wide so N = capacity is reachable.
  - If this was word N-1 -> CHECK, otherwise stay in DATA.
- Write address bound: the maximum write address is (2^(AddressWidth-2)-1)*4, i.e. 0x3FC at default. Addresses never wrap.
- CHECK: accepted byte is compared with the checksum. Equal -> DONE. Unequal -> ERROR with err_o = 2. Words already written stay written.
- DONE: done_o = 1 and cpu_rst_o = 0. start_i -> SYNC, which clears done_o, err_o and the checksum and reasserts cpu_rst_o in the following cycle.
- ERROR: err_o is held, done_o = 0, cpu_rst_o = 1. start_i -> SYNC and clears err_o.
- start_i while busy_o = 1 is ignored; no restart.
- rst_i mid-load: it wins over every other event, including a lane-3 acceptance in the same cycle. All outputs return to their reset values, no write strobe follows, and a partial word is discarded.

Decomposition:
- Shared package loader_pkg contains:
  - the state enum (IDLE, SYNC, LEN_LO, LEN_HI, DATA, CHECK, DONE, ERROR);
  - localparam SYNC_BYTE = 8'hA5;
  - error code constants ERR_NONE = 0, ERR_LEN = 1, ERR_SUM = 2.
- One sub-module, byte_packer, holds the lane counter, shifts bytes into a 32-bit word and pulses word_valid_o when a word completes. The top level holds the FSM, length register, word counter and checksum.

Test Plan:
1. Reset check: assert rst_i for 2 cycles -> every output at its reset value, cpu_rst_o 1, rx_ready_o 0. Bytes sent without start_i are not accepted.
2. Good load: start, then send A5 02 00 78 56 34 12 EF BE AD DE 2A.
   - Writes: addr 0x000 data 0x12345678, then addr 0x004 data 0xDEADBEEF, each a one-cycle strobe.
   - Final state: done_o 1, err_o 0, cpu_rst_o 0, busy_o 0.
3. Bad checksum: same frame ending in 2B -> both words written, then err_o 2, done_o 0, cpu_rst_o 1. Issuing start_i clears err_o and busy_o goes to 1.
4. Bad length: frame A5 00 00 -> err_o 1, no write. Frame A5 01 01 (N = 257) -> err_o 1, no write.
5. Noise and backpressure: bytes 00 FF 5A, then a valid N = 1 frame, with rx_valid_i randomly toggling -> noise discarded, one write to 0x000, done_o 1.
6. Capacity and reset: N = 256 (A5 00 01) -> last write at 0x3FC and done_o 1. Repeat with rst_i pulsed after the second byte of word 10 -> IDLE, no further strobes, cpu_rst_o 1.
